// File: rtl/rv_wb_pkg.sv
// Shared definitions for the register-file writeback block: load kinds,
// writeback buffer depth, retired-write counter width and the buffer entry.
package rv_wb_pkg;

  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_COUNT_W    = 16;
  localparam int WB_OCC_W      = $clog2(WB_FIFO_DEPTH + 1);

  // Encodings 6 and 7 are reserved and behave like WB_ALU.
  typedef enum logic [2:0] {
    WB_ALU = 3'd0,
    WB_LB  = 3'd1,
    WB_LH  = 3'd2,
    WB_LW  = 3'd3,
    WB_LBU = 3'd4,
    WB_LHU = 3'd5
  } wb_kind_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_if.sv
// Writeback request bus: valid/ready handshake plus register index, raw
// data, load kind and the low address bits used for sub-word selection.
interface rf_writeback_if;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [2:0]  wb_kind;
  logic [1:0]  wb_addr_lo;

  modport master (
    output wb_valid, wb_reg, wb_data, wb_kind, wb_addr_lo,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, wb_kind, wb_addr_lo,
    output wb_ready
  );

endinterface

// File: rtl/wb_load_align.sv
// Load formatting: picks the addressed byte/halfword out of the raw load word
// and sign- or zero-extends it. ALU results, LW and reserved kinds pass through.
module wb_load_align
  import rv_wb_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  kind,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data_fmt
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to the load kind.
  always_comb begin
    byte_sel = data[7:0];
    case (addr_lo)
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      2'd3:    byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase

    // Halfword lane comes from bit 1 only; a misaligned bit 0 is ignored.
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];

    data_fmt = data;
    case (kind)
      WB_LB:   data_fmt = {{24{byte_sel[7]}}, byte_sel};
      WB_LH:   data_fmt = {{16{half_sel[15]}}, half_sel};
      WB_LBU:  data_fmt = {24'd0, byte_sel};
      WB_LHU:  data_fmt = {16'd0, half_sel};
      default: data_fmt = data;
    endcase
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback stage. Accepted requests are formatted on entry and
// queued in a two-entry buffer whose head drives the regfile write port.
// The write strobe is the head-valid flag gated by rf_busy, so an entry
// accepted on one edge can be written in the very next cycle, and the strobe
// drops immediately when the regfile reports busy. Writes to x0 are dropped.
// Build option: define RF_WRITEBACK_FWD_EN to enable the forwarding lookup
// (otherwise fwd_hit/fwd_data are constant zero).
module rf_writeback
  import rv_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  rf_writeback_if.slave         wb,
  input  logic                  rf_busy,
  output logic                  rf_write_en,
  output logic [4:0]            rf_write_reg,
  output logic [31:0]           rf_write_data,
  input  logic [4:0]            fwd_reg,
  output logic                  fwd_hit,
  output logic [31:0]           fwd_data,
  output logic [WB_COUNT_W-1:0] wb_count
);

  localparam logic [WB_OCC_W-1:0] OCC_FULL = WB_OCC_W'(WB_FIFO_DEPTH);
  localparam logic [WB_OCC_W-1:0] OCC_ONE  = WB_OCC_W'(1);

  // q[0] is always the head (oldest) entry.
  wb_entry_t            q [WB_FIFO_DEPTH];
  logic [WB_OCC_W-1:0]  occ;
  logic [31:0]          fmt_data;
  wb_entry_t            in_entry;
  logic                 accept;
  logic                 push;
  logic                 pop;

  wb_load_align u_align (
    .data     (wb.wb_data),
    .kind     (wb.wb_kind),
    .addr_lo  (wb.wb_addr_lo),
    .data_fmt (fmt_data)
  );

  assign in_entry      = '{rd: wb.wb_reg, data: fmt_data};
  assign wb.wb_ready   = (occ != OCC_FULL);
  assign accept        = wb.wb_valid & wb.wb_ready;
  assign push          = accept & (wb.wb_reg != 5'd0);
  assign pop           = (occ != '0) & ~rf_busy;

  assign rf_write_en   = pop;
  assign rf_write_reg  = q[0].rd;
  assign rf_write_data = q[0].data;

  // Buffer update: push at the tail, pop by shifting the second slot forward.
  // A push with pop only happens at occupancy 1 since full blocks accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
      for (int i = 0; i < WB_FIFO_DEPTH; i++) q[i] <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == '0) q[0] <= in_entry;
          else           q[1] <= in_entry;
          occ <= occ + OCC_ONE;
        end
        2'b01: begin
          if (occ == OCC_FULL) q[0] <= q[1];
          occ <= occ - OCC_ONE;
        end
        2'b11: begin
          if (occ == OCC_FULL) begin
            q[0] <= q[1];
            q[1] <= in_entry;
          end else begin
            q[0] <= in_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // Retired-write counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wb_count <= '0;
    else if (pop) wb_count <= wb_count + WB_COUNT_W'(1);
  end

`ifdef RF_WRITEBACK_FWD_EN
  // Youngest matching pending entry wins; x0 never forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_reg != 5'd0) begin
      if ((occ == OCC_FULL) && (q[1].rd == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = q[1].data;
      end else if ((occ != '0) && (q[0].rd == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = q[0].data;
      end
    end
  end
`else
  logic unused_fwd_reg;
  assign unused_fwd_reg = ^fwd_reg;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = '0;
`endif

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state rising-edge.
REQ-002 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have port: wb_valid  input  1  writeback request present.
REQ-004 SHALL have port: wb_ready  output  1  request buffer can accept.
REQ-005 SHALL have port: wb_reg  input  5  destination register index.
REQ-006 SHALL have port: wb_data  input  32  ALU result or raw load word.
REQ-007 SHALL have port: wb_kind  input  3  0 ALU, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6-7 reserved.
REQ-008 SHALL have port: wb_addr_lo  input  2  load address bits [1:0].
REQ-009 SHALL have port: rf_busy  input  1  regfile write port unavailable this cycle.
REQ-010 SHALL have ports: rf_write_en  output  1; rf_write_reg  output  5; rf_write_data  output  32, all driving the regfile write port.
REQ-011 SHALL have ports: fwd_reg  input  5; fwd_hit  output  1; fwd_data  output  32 (forwarding lookup).
REQ-012 SHALL have port: wb_count  output  16  retired-write counter.

Function
REQ-013 SHALL hold a 2-entry FIFO of {reg, formatted data}; wb_ready = not full (no pass-through when full).
REQ-014 SHALL accept on wb_valid & wb_ready; data formatted at accept: LB/LH sign-extend, LBU/LHU zero-extend, LW/ALU unchanged.
REQ-015 SHALL select byte by wb_addr_lo[1:0] and halfword by wb_addr_lo[1]; wb_addr_lo[0] ignored for LH/LHU; wb_addr_lo ignored for LW/ALU.
REQ-016 SHALL treat reserved wb_kind as ALU.
REQ-017 SHALL discard accepted requests with wb_reg==0 (not enqueued, not counted, wb_ready unaffected).
REQ-018 SHALL assert rf_write_en for exactly one cycle per entry when FIFO non-empty and rf_busy==0, presenting head reg/data registered; entry popped that same cycle.
REQ-019 SHALL give latency: request accepted in cycle N appears on rf_write_en at earliest cycle N+1.
REQ-020 SHALL allow simultaneous push and pop in one cycle; occupancy unchanged, order preserved.
REQ-021 SHALL hold rf_write_reg/rf_write_data stable and rf_write_en low while rf_busy==1.
REQ-022 SHALL increment wb_count by 1 per rf_write_en cycle, wrapping 0xFFFF->0x0000.

Reset
REQ-023 SHALL on rst clear FIFO (pending entries dropped), rf_write_en=0, rf_write_reg=0, rf_write_data=0, wb_count=0, fwd_hit=0, fwd_data=0, wb_ready=1.
REQ-024 SHALL apply reset asynchronously mid-operation; first acceptance possible in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL with RF_WRITEBACK_FWD_EN defined: fwd_hit=1 combinationally when fwd_reg!=0 matches any FIFO entry or the entry on the write port this cycle; fwd_data = youngest match.
REQ-026 SHALL without RF_WRITEBACK_FWD_EN: fwd_hit and fwd_data tied to 0, no compare logic.

Structure
REQ-027 SHALL place wb_kind encodings, FIFO depth constant (2) and counter width (16) in shared package rv_wb_pkg.
REQ-028 SHALL implement load formatting in sub-module wb_load_align (combinational: data, kind, addr_lo -> formatted data).

Verification
REQ-029 SHALL cover: LB data=0x1234_80FF, addr_lo=1, reg=5 -> next cycle rf_write_en=1, reg=5, data=0xFFFF_FF80.
REQ-030 SHALL cover: LHU data=0x8001_7FFF, addr_lo=2, reg=7 -> data=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-031 SHALL cover: rf_busy=1, 3 ALU writes to regs 1,2,3 -> wb_ready=0 after two; release rf_busy -> writes 1,2,3 in order over 3 cycles, wb_count=3.
REQ-032 SHALL cover: ALU write reg=0 data=0xDEAD_BEEF -> no rf_write_en, wb_count unchanged.
REQ-033 SHALL cover: with FWD_EN, rf_busy=1, entries reg4=0x11 then reg4=0x22, fwd_reg=4 -> fwd_hit=1, fwd_data=0x22; fwd_reg=0 -> fwd_hit=0.
REQ-034 SHALL cover: two entries pending, rst pulsed -> no rf_write_en after reset, wb_count=0, wb_ready=1.
